// File: rtl/dram_req_queue.sv
// In-order request FIFO in front of a DRAM controller. One request is issued at a time.
// Reads return a one-cycle response pulse, writes are posted, and a stuck request is aborted after TIMEOUT cycles.
module dram_req_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cpu_valid,
  output logic                     cpu_ready,
  input  logic                     cpu_we,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_timeout
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nxt;

  logic                  q_we    [DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] q_wdata [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [OW-1:0]         count;
  logic [TW-1:0]         tcnt;
  logic                  issue_we, timeout_hit, push, pop;

  // Full blocks a push even if IDLE pops the head on the same edge.
  assign cpu_ready   = (count != OW'(DEPTH));
  assign push        = cpu_valid && cpu_ready;
  assign occupancy   = count;
  assign timeout_hit = (state == ISSUE) && (tcnt == TW'(TIMEOUT));
  // The request drops in the completion cycle, so the controller never sees it twice.
  assign mem_re = (state == ISSUE) && !issue_we && !mem_ready && !timeout_hit;
  assign mem_we = (state == ISSUE) &&  issue_we && !mem_ready && !timeout_hit;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop       = 1'b1;
        state_nxt = ISSUE;
      end
      ISSUE: if (mem_ready || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_we[wr_ptr]    <= cpu_we;
      q_addr[wr_ptr]  <= cpu_addr;
      q_wdata[wr_ptr] <= cpu_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      issue_we    <= 1'b0;
      tcnt        <= '0;
      err_timeout <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (pop) begin
        mem_addr  <= q_addr[rd_ptr];
        mem_wdata <= q_wdata[rd_ptr];
        issue_we  <= q_we[rd_ptr];
        tcnt      <= '0;
      end else if (state == ISSUE) begin
        // A completion that coincides with the timeout is still a normal completion.
        if (mem_ready) begin
          if (!issue_we) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem_rdata;
          end
        end else if (timeout_hit) begin
          err_timeout <= 1'b1;
          if (!issue_we) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
          end
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_dram_req_queue.sv
// Directed bench for dram_req_queue: single read, fill/full, ordering with wrap, timeout, push/pop and reset.
module tb_dram_req_queue;
  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_valid, cpu_ready, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re, mem_ready;
  logic [2:0]  occupancy;
  logic        err_timeout;

  int nchk = 0;
  int nfail = 0;
  logic        auto_rsp = 1'b0;
  int          hi_win = 0;
  logic [31:0] obs_addr[$];
  logic        obs_we[$];
  logic [31:0] obs_rsp[$];
  logic [31:0] exp_addr[$];
  logic        exp_we[$];
  logic [31:0] exp_rsp[$];

  dram_req_queue #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4), .TIMEOUT(255)) dut (
    .clk(clk), .resetn(resetn), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .occupancy(occupancy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; in auto mode act as a controller answering after 3 request cycles.
  task automatic tick();
    @(posedge clk); #1;
    if (auto_rsp) begin
      if (rsp_valid) obs_rsp.push_back(rsp_rdata);
      if (mem_ready) mem_ready = 1'b0;
      else if (mem_re || mem_we) begin
        if (hi_win == 3) begin
          mem_ready = 1'b1;
          mem_rdata = {16'hC0DE, mem_addr[15:0]};
          obs_addr.push_back(mem_addr);
          obs_we.push_back(mem_we);
          hi_win = 0;
        end else hi_win++;
      end
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_valid = v; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int hi;
    int guard;
    logic [9:0] wpat;
    resetn = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    drive(1'b0, 1'b0, '0, '0);
    tick(); tick();
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_ready", 64'(cpu_ready), 64'(1));
    chk("rst_re", 64'(mem_re), 64'(0));
    chk("rst_we", 64'(mem_we), 64'(0));
    chk("rst_rsp", 64'(rsp_valid), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    resetn = 1'b1;

    // Single read, ready after 6 request cycles
    drive(1'b1, 1'b0, 32'h0000_0400, '0);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("rd_occ1", 64'(occupancy), 64'(1));
    chk("rd_re_pre", 64'(mem_re), 64'(0));
    tick();
    chk("rd_addr", 64'(mem_addr), 64'h400);
    chk("rd_occ0", 64'(occupancy), 64'(0));
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_re) hi++;
      tick();
    end
    chk("rd_re_cycles", 64'(hi), 64'(6));
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
    chk("rd_re_drop", 64'(mem_re), 64'(0));
    tick();
    mem_ready = 1'b0;
    chk("rd_rsp_v", 64'(rsp_valid), 64'(1));
    chk("rd_rsp_d", 64'(rsp_rdata), 64'hDEAD_BEEF);
    tick();
    chk("rd_rsp_pulse", 64'(rsp_valid), 64'(0));

    // Fill to full with writes; no completion while filling
    drive(1'b1, 1'b1, 32'h100, 32'hA0); tick();
    chk("fill_occ_a", 64'(occupancy), 64'(1));
    drive(1'b1, 1'b1, 32'h101, 32'hA1); tick();
    chk("fill_pushpop", 64'(occupancy), 64'(1));
    chk("fill_we", 64'(mem_we), 64'(1));
    chk("fill_addr0", 64'(mem_addr), 64'h100);
    drive(1'b1, 1'b1, 32'h102, 32'hA2); tick();
    chk("fill_occ2", 64'(occupancy), 64'(2));
    drive(1'b1, 1'b1, 32'h103, 32'hA3); tick();
    drive(1'b1, 1'b1, 32'h104, 32'hA4); tick();
    chk("fill_occ4", 64'(occupancy), 64'(4));
    chk("full_ready", 64'(cpu_ready), 64'(0));
    drive(1'b1, 1'b1, 32'h105, 32'hA5);
    tick(); tick();
    chk("full_hold_occ", 64'(occupancy), 64'(4));
    chk("full_wdata", 64'(mem_wdata), 64'hA0);
    mem_ready = 1'b1; #1;
    chk("full_we_drop", 64'(mem_we), 64'(0));
    tick();
    mem_ready = 1'b0;
    chk("full_nopass", 64'(cpu_ready), 64'(0));
    tick();
    chk("full_pop_occ", 64'(occupancy), 64'(3));
    chk("full_pop_addr", 64'(mem_addr), 64'h101);
    tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("full_5th_in", 64'(occupancy), 64'(4));
    mem_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      tick(); tick();
      chk("drain_addr", 64'(mem_addr), 64'(32'h100 + i));
      chk("drain_norsp", 64'(rsp_valid), 64'(0));
    end
    tick();
    mem_ready = 1'b0;
    chk("drain_occ", 64'(occupancy), 64'(0));
    chk("drain_rsp", 64'(rsp_valid), 64'(0));

    // Ten mixed requests, ordering and pointer wrap
    wpat = 10'b0110100101;
    auto_rsp = 1'b1; hi_win = 0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = 32'h2000 + 32'(i * 4);
      exp_addr.push_back(a);
      exp_we.push_back(wpat[i]);
      if (!wpat[i]) exp_rsp.push_back({16'hC0DE, a[15:0]});
      drive(1'b1, wpat[i], a, 32'h7700 + 32'(i));
      guard = 0;
      while (!cpu_ready && guard < 100) begin tick(); guard++; end
      if (guard >= 100) chk("ord_push_wait", 64'(cpu_ready), 64'(1));
      tick();
    end
    drive(1'b0, 1'b0, '0, '0);
    repeat (80) tick();
    auto_rsp = 1'b0; mem_ready = 1'b0;
    chk("ord_count", 64'(obs_addr.size()), 64'(10));
    for (int i = 0; i < 10; i++) begin
      if (i < obs_addr.size()) begin
        chk("ord_addr", 64'(obs_addr[i]), 64'(exp_addr[i]));
        chk("ord_we", 64'(obs_we[i]), 64'(exp_we[i]));
      end
    end
    chk("ord_rsp_count", 64'(obs_rsp.size()), 64'(exp_rsp.size()));
    for (int i = 0; i < exp_rsp.size(); i++)
      if (i < obs_rsp.size()) chk("ord_rsp", 64'(obs_rsp[i]), 64'(exp_rsp[i]));
    chk("ord_occ", 64'(occupancy), 64'(0));

    // mem_ready while IDLE does nothing
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick();
    chk("idle_ready_rsp", 64'(rsp_valid), 64'(0));
    chk("idle_ready_re", 64'(mem_re), 64'(0));

    // Ready at the same cycle as the timeout wins
    drive(1'b1, 1'b0, 32'h3000, '0); tick();
    drive(1'b0, 1'b0, '0, '0); tick();
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (mem_re) hi++;
      tick();
    end
    chk("to_hi_a", 64'(hi), 64'(255));
    chk("to_drop_a", 64'(mem_re), 64'(0));
    mem_ready = 1'b1; mem_rdata = 32'h5A5A_1234;
    tick();
    mem_ready = 1'b0;
    chk("to_race_rsp", 64'(rsp_valid), 64'(1));
    chk("to_race_data", 64'(rsp_rdata), 64'h5A5A_1234);
    chk("to_race_err", 64'(err_timeout), 64'(0));

    // Genuine timeout on a read, then the queued write issues
    drive(1'b1, 1'b0, 32'h3008, '0); tick();
    drive(1'b1, 1'b1, 32'h300C, 32'h55); tick();
    drive(1'b0, 1'b0, '0, '0);
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      if (mem_re) hi++;
      tick();
    end
    chk("to_hi_b", 64'(hi), 64'(255));
    chk("to_drop_b", 64'(mem_re), 64'(0));
    chk("to_err_pre", 64'(err_timeout), 64'(0));
    tick();
    chk("to_err", 64'(err_timeout), 64'(1));
    chk("to_rsp_v", 64'(rsp_valid), 64'(1));
    chk("to_rsp_d", 64'(rsp_rdata), 64'(0));
    tick();
    chk("to_next_we", 64'(mem_we), 64'(1));
    chk("to_next_addr", 64'(mem_addr), 64'h300C);
    chk("to_next_rsp", 64'(rsp_valid), 64'(0));
    mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick();
    chk("to_sticky", 64'(err_timeout), 64'(1));
    chk("to_occ", 64'(occupancy), 64'(0));

    // Simultaneous push and pop at occupancy 2
    drive(1'b1, 1'b1, 32'h4000, 32'h1); tick();
    drive(1'b1, 1'b0, 32'h4004, 32'h0); tick();
    drive(1'b1, 1'b1, 32'h4008, 32'h2); tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("pp_occ_pre", 64'(occupancy), 64'(2));
    mem_ready = 1'b1; tick(); mem_ready = 1'b0;
    chk("pp_idle_occ", 64'(occupancy), 64'(2));
    drive(1'b1, 1'b1, 32'h400C, 32'h3); tick();
    chk("pp_occ", 64'(occupancy), 64'(2));
    chk("pp_re", 64'(mem_re), 64'(1));
    chk("pp_addr", 64'(mem_addr), 64'h4004);
    drive(1'b1, 1'b1, 32'h4010, 32'h4); tick();
    drive(1'b0, 1'b0, '0, '0);
    chk("mid_occ3", 64'(occupancy), 64'(3));

    // Reset while a read is in flight with three queued
    resetn = 1'b0; tick();
    chk("mid_rst_occ", 64'(occupancy), 64'(0));
    chk("mid_rst_re", 64'(mem_re), 64'(0));
    chk("mid_rst_we", 64'(mem_we), 64'(0));
    chk("mid_rst_rsp", 64'(rsp_valid), 64'(0));
    chk("mid_rst_ready", 64'(cpu_ready), 64'(1));
    chk("mid_rst_err", 64'(err_timeout), 64'(0));
    resetn = 1'b1; tick();
    chk("post_rst_rsp", 64'(rsp_valid), 64'(0));
    chk("post_rst_re", 64'(mem_re), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
